// File: rtl/img_pkg.sv
// Shared types for the image window streamer:
// FSM states, edge-handling modes, slot tag and clog2.
package img_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int EDGE_ZERO  = 0;
  localparam int EDGE_CLAMP = 1;

  typedef struct packed {
    logic rd;
    logic eol;
    logic last;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/img_win_fifo.sv
// First-word-fall-through FIFO for streamed window pixels.
// Ports: push/din, pop/dout, full, empty, count; dout is the head entry.
module img_win_fifo
  import img_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] P_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == C_FULL);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (do_pop)
      rd_d = (rd_q == P_LAST) ? '0 : rd_q + PTR_W'(1);
    if (do_push)
      wr_d = (wr_q == P_LAST) ? '0 : wr_q + PTR_W'(1);
    if (do_push && !do_pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push)
        mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/img_window_stream.sv
// Fetches a WIN x WIN window from padded image BRAM and streams it
// raster-order over valid/ready (pix_*), with start/busy/done/err control.
module img_window_stream
  import img_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 17,
  parameter int IMG_W     = 194,
  parameter int IMG_H     = 194,
  parameter int BASE_ADDR = 22500,
  parameter int WIN       = 45,
  parameter int ORIG_X    = 45,
  parameter int ORIG_Y    = 45,
  parameter int STRIDE    = 1,
  parameter int RD_LAT    = 2,
  parameter int EDGE_MODE = 0,
  parameter int IDX_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  win_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int CNT_W = clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = clog2(2 * FIFO_DEPTH + 1);
  localparam int R_SPAN = (ORIG_Y - 1) * STRIDE + WIN;
  localparam int C_SPAN = (ORIG_X - 1) * STRIDE + WIN;
  localparam int RC_W = clog2(R_SPAN + C_SPAN + IMG_H + IMG_W);
  localparam int WC_W = clog2(WIN + 1);
  localparam int AW = ADDR_W + 1;

  localparam logic [RC_W-1:0] H_LAST = RC_W'(IMG_H - 1);
  localparam logic [RC_W-1:0] W_LAST = RC_W'(IMG_W - 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN - 1);
  localparam logic [AW-1:0] A_BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] A_ROW = AW'(IMG_W);
  localparam logic [31:0] NUM_WIN_L = 32'(ORIG_X * ORIG_Y);
  localparam logic [OCC_W-1:0] O_DEPTH = OCC_W'(FIFO_DEPTH);

  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic err_q, err_d;
  logic [RC_W-1:0] r_q, r_d, c_q, c_d, c0_q, c0_d;
  logic [WC_W-1:0] wr_q, wr_d, wc_q, wc_d;
  logic [AW-1:0] addr_q, addr_d, row_q, row_d;
  logic [RD_LAT-1:0] dl_vld_q, dl_vld_d;
  tag_t [RD_LAT-1:0] dl_tag_q, dl_tag_d;

  logic [31:0] idx_w;
  logic [RC_W-1:0] r0, c0, r0_cl, c0_cl;
  logic [AW-1:0] a0;
  logic idx_bad, oob, last_col, last_row;
  logic issue, rd_en, pop;
  logic [OCC_W-1:0] occ;
  tag_t new_tag, out_tag;

  logic fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PIX_W+1:0] fifo_din, fifo_dout;

  // Origin decode; divisor is a constant.
  always_comb begin
    idx_w = 32'(idx_q);
    r0 = RC_W'((idx_w / 32'(ORIG_X)) * 32'(STRIDE));
    c0 = RC_W'((idx_w % 32'(ORIG_X)) * 32'(STRIDE));
    r0_cl = (r0 > H_LAST) ? H_LAST : r0;
    c0_cl = (c0 > W_LAST) ? W_LAST : c0;
    a0 = A_BASE + AW'(r0_cl) * A_ROW + AW'(c0_cl);
    idx_bad = (idx_w >= NUM_WIN_L);
  end

  // Only in-flight slots (delay line + FIFO) are counted, so the
  // FIFO can never overflow regardless of backpressure.
  always_comb begin
    occ = OCC_W'(fifo_cnt);
    for (int i = 0; i < RD_LAT; i++)
      occ = occ + OCC_W'(dl_vld_q[i]);
    oob = (r_q > H_LAST) || (c_q > W_LAST);
    last_col = (wc_q == WIN_LAST);
    last_row = (wr_q == WIN_LAST);
    issue = (state_q == S_ISSUE) && (occ < O_DEPTH) && !fifo_full;
    rd_en = issue && ((EDGE_MODE == EDGE_CLAMP) || !oob);
    new_tag = '{rd: rd_en, eol: last_col, last: last_col && last_row};
  end

  // addr tracks the clamped (r,c); in zero mode it is unused
  // for out-of-image slots since no read is issued.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    c0_d = c0_q;
    wr_d = wr_q;
    wc_d = wc_q;
    addr_d = addr_q;
    row_d = row_q;
    if (state_q == S_DECODE) begin
      r_d = r0;
      c_d = c0;
      c0_d = c0;
      wr_d = '0;
      wc_d = '0;
      addr_d = a0;
      row_d = a0;
    end else if (issue) begin
      if (last_col) begin
        wc_d = '0;
        wr_d = wr_q + WC_W'(1);
        r_d = r_q + RC_W'(1);
        c_d = c0_q;
        row_d = row_q + ((r_q < H_LAST) ? A_ROW : '0);
        addr_d = row_d;
      end else begin
        wc_d = wc_q + WC_W'(1);
        c_d = c_q + RC_W'(1);
        addr_d = addr_q + ((c_q < W_LAST) ? AW'(1) : AW'(0));
      end
    end
  end

  always_comb begin
    dl_vld_d[0] = issue;
    dl_tag_d[0] = new_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      err_q <= 1'b0;
      r_q <= '0;
      c_q <= '0;
      c0_q <= '0;
      wr_q <= '0;
      wc_q <= '0;
      addr_q <= '0;
      row_q <= '0;
      dl_vld_q <= '0;
      dl_tag_q <= '0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      r_q <= r_d;
      c_q <= c_d;
      c0_q <= c0_d;
      wr_q <= wr_d;
      wc_q <= wc_d;
      addr_q <= addr_d;
      row_q <= row_d;
      dl_vld_q <= dl_vld_d;
      dl_tag_q <= dl_tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DECODE;
          idx_d = win_idx;
          err_d = 1'b0;
        end
      end
      S_DECODE: begin
        state_d = idx_bad ? S_DONE : S_ISSUE;
        err_d = idx_bad;
      end
      S_ISSUE: begin
        if (issue && last_col && last_row)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && pix_last)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_DECODE) || (state_q == S_ISSUE)
        || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
    err = done && err_q;
    mem_ren = rd_en;
    mem_addr = rd_en ? ADDR_W'(addr_q) : '0;
  end

  assign out_tag = dl_tag_q[RD_LAT-1];
  assign fifo_din = {out_tag.eol, out_tag.last,
                     out_tag.rd ? mem_rdata : '0};

  img_win_fifo #(
    .WIDTH(PIX_W + 2),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (dl_vld_q[RD_LAT-1]),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  assign pix_valid = !fifo_empty;
  assign pop = pix_valid && pix_ready;
  assign {pix_eol, pix_last, pix_data} = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_img_window_stream.sv
// Directed bench for img_window_stream: default geometry plus
// two 8x8 instances (zero-fill and clamp edge handling).
module tb_img_window_stream;

  localparam int W = 45;
  localparam int IW = 194;
  localparam int BASE = 22500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start = 1'b0;
  logic [14:0] win_idx = '0;
  logic pix_ready = 1'b1;
  logic busy, done, err, mem_ren, pix_valid, pix_eol, pix_last;
  logic [16:0] mem_addr;
  logic [7:0] mem_rdata, pix_data;

  logic sm_start = 1'b0;
  logic [14:0] sm_idx = '0;
  logic sm_ready = 1'b1;
  logic s0_busy, s0_done, s0_err, s0_ren, s0_valid, s0_eol, s0_last;
  logic s1_busy, s1_done, s1_err, s1_ren, s1_valid, s1_eol, s1_last;
  logic [16:0] s0_addr, s1_addr;
  logic [7:0] s0_rdata, s1_rdata, s0_data, s1_data;

  img_window_stream u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_idx(win_idx),
    .busy(busy), .done(done), .err(err),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_last(pix_last)
  );

  img_window_stream #(
    .IMG_W(8), .IMG_H(8), .WIN(3), .ORIG_X(8), .ORIG_Y(8),
    .EDGE_MODE(0)
  ) u_sm0 (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .win_idx(sm_idx),
    .busy(s0_busy), .done(s0_done), .err(s0_err),
    .mem_ren(s0_ren), .mem_addr(s0_addr), .mem_rdata(s0_rdata),
    .pix_data(s0_data), .pix_valid(s0_valid), .pix_ready(sm_ready),
    .pix_eol(s0_eol), .pix_last(s0_last)
  );

  img_window_stream #(
    .IMG_W(8), .IMG_H(8), .WIN(3), .ORIG_X(8), .ORIG_Y(8),
    .EDGE_MODE(1)
  ) u_sm1 (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .win_idx(sm_idx),
    .busy(s1_busy), .done(s1_done), .err(s1_err),
    .mem_ren(s1_ren), .mem_addr(s1_addr), .mem_rdata(s1_rdata),
    .pix_data(s1_data), .pix_valid(s1_valid), .pix_ready(sm_ready),
    .pix_eol(s1_eol), .pix_last(s1_last)
  );

  // 2-cycle BRAM models, mem[a] = a[7:0]
  logic [7:0] m0a = '0, m0b = '0, m1a = '0, m1b = '0, m2a = '0, m2b = '0;
  always @(posedge clk) begin
    if (mem_ren) m0a <= mem_addr[7:0];
    m0b <= m0a;
    if (s0_ren) m1a <= s0_addr[7:0];
    m1b <= m1a;
    if (s1_ren) m2a <= s1_addr[7:0];
    m2b <= m2a;
  end
  assign mem_rdata = m0b;
  assign s0_rdata = m1b;
  assign s1_rdata = m2b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  int r_npix, r_bad_d, r_bad_e, r_bad_l, r_bad_h, r_occ;
  int r_fv, r_mr, r_done, r_err, r_to, r_addr0, r_busy_dn;
  int r_first_hs, r_last_hs, r_gap;

  task automatic run_win(input int idx, input bit rnd, input int abort_at,
                         input int bstart_at, input int exp_base);
    int k0, issued, k, ev, lhs;
    bit stall;
    logic [7:0] pd;
    logic pe, pl;
    r_npix = 0; r_bad_d = 0; r_bad_e = 0; r_bad_l = 0; r_bad_h = 0;
    r_occ = 0; r_fv = -1; r_mr = -1; r_done = -1; r_err = 0; r_to = 1;
    r_addr0 = -1; r_busy_dn = -1; r_first_hs = -1; r_last_hs = -1;
    r_gap = -1; issued = 0; stall = 0; lhs = -1;
    pd = '0; pe = 0; pl = 0;
    @(negedge clk);
    start = 1'b1;
    win_idx = 15'(idx);
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k0 = cyc;
    for (int t = 0; t < 20000; t++) begin
      if (done) begin
        r_done = cyc - k0 + 1;
        r_err = int'(err);
        r_busy_dn = int'(busy);
        if (lhs >= 0) r_gap = cyc - lhs;
        r_to = 0;
        break;
      end
      start = (t == bstart_at);
      if (t == bstart_at) win_idx = 15'd5;
      if (mem_ren && r_mr < 0) begin
        r_mr = cyc - k0 + 1;
        r_addr0 = int'(mem_addr);
      end
      if (pix_valid && r_fv < 0) r_fv = cyc - k0 + 1;
      if (issued - r_npix > r_occ) r_occ = issued - r_npix;
      if (stall && !(pix_valid && pix_data === pd && pix_eol === pe
                     && pix_last === pl))
        r_bad_h++;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        k = r_npix;
        ev = (exp_base + (k / W) * IW + k % W) & 255;
        if (pix_data !== 8'(ev)) r_bad_d++;
        if (pix_eol !== (k % W == W - 1)) r_bad_e++;
        if (pix_last !== (k == W * W - 1)) r_bad_l++;
        if (r_first_hs < 0) r_first_hs = cyc;
        r_last_hs = cyc;
        if (pix_last) lhs = cyc;
        r_npix++;
      end
      stall = pix_valid && !pix_ready;
      pd = pix_data; pe = pix_eol; pl = pix_last;
      if (mem_ren) issued++;
      if (abort_at > 0 && r_npix == abort_at) begin
        start = 1'b0;
        @(posedge clk);
        r_to = 0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    pix_ready = 1'b1;
  endtask

  logic [7:0] s0_px [9];
  logic [7:0] s1_px [9];

  initial begin
    int n0r, n1r, c0n, c1n, acc, a;
    bit d0, d1;

    #1;
    chk("rst_ctl", {busy, done, err, mem_ren, pix_valid, pix_eol,
                    pix_last}, 0);
    chk("rst_addr_data", {mem_addr, pix_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: full window, always ready
    run_win(0, 0, 0, -1, BASE);
    chk("t1_timeout", r_to, 0);
    chk("t1_npix", r_npix, W * W);
    chk("t1_data", r_bad_d, 0);
    chk("t1_eol", r_bad_e, 0);
    chk("t1_last", r_bad_l, 0);
    chk("t1_ren_lat", r_mr, 2);
    chk("t1_addr0", r_addr0, BASE);
    chk("t1_valid_lat", r_fv, 5);
    chk("t1_rate", r_last_hs - r_first_hs, W * W - 1);
    chk("t1_done_gap", r_gap, 1);
    chk("t1_err", r_err, 0);
    chk("t1_busy_at_done", r_busy_dn, 0);
    @(negedge clk);
    chk("t1_done_pulse", {done, busy}, 0);

    // 2: interior origin with random backpressure
    run_win(46, 1, 0, -1, BASE + IW + 1);
    chk("t2_timeout", r_to, 0);
    chk("t2_npix", r_npix, W * W);
    chk("t2_data", r_bad_d, 0);
    chk("t2_eol", r_bad_e, 0);
    chk("t2_last", r_bad_l, 0);
    chk("t2_hold", r_bad_h, 0);
    chk("t2_occ_le4", r_occ <= 4, 1);
    chk("t2_addr0", r_addr0, BASE + IW + 1);

    // 4: out-of-range index
    run_win(W * W, 0, 0, -1, BASE);
    chk("t4_timeout", r_to, 0);
    chk("t4_done_lat", r_done, 2);
    chk("t4_err", r_err, 1);
    chk("t4_no_ren", r_mr, -1);
    chk("t4_no_valid", r_fv, -1);
    @(negedge clk);
    chk("t4_err_pulse", {done, err}, 0);

    // 5: asynchronous reset mid-window
    run_win(0, 0, 100, -1, BASE);
    chk("t5_timeout", r_to, 0);
    chk("t5_data_pre", r_bad_d, 0);
    #1;
    chk("t5_pre_active", {busy, pix_valid}, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ctl", {busy, done, err, mem_ren, pix_valid, pix_eol,
                       pix_last}, 0);
    chk("t5_rst_addr_data", {mem_addr, pix_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_win(0, 0, 0, -1, BASE);
    chk("t5_timeout2", r_to, 0);
    chk("t5_npix", r_npix, W * W);
    chk("t5_data", r_bad_d, 0);
    chk("t5_addr0", r_addr0, BASE);

    // 6: start while busy is ignored
    run_win(0, 0, 0, 10, BASE);
    chk("t6_timeout", r_to, 0);
    chk("t6_npix_a", r_npix, W * W);
    chk("t6_data_a", r_bad_d, 0);
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      acc = acc | int'({busy, mem_ren, pix_valid});
    end
    chk("t6_idle_between", acc, 0);
    run_win(1, 0, 0, -1, BASE + 1);
    chk("t6_timeout2", r_to, 0);
    chk("t6_npix_b", r_npix, W * W);
    chk("t6_data_b", r_bad_d, 0);
    chk("t6_addr0_b", r_addr0, BASE + 1);

    // 3: right-edge window on 8x8 image, zero-fill vs clamp
    @(negedge clk);
    sm_start = 1'b1;
    sm_idx = 15'd7;
    @(negedge clk);
    sm_start = 1'b0;
    n0r = 0; n1r = 0; c0n = 0; c1n = 0; d0 = 0; d1 = 0;
    for (int t = 0; t < 100 && !(d0 && d1); t++) begin
      if (s0_ren) n0r++;
      if (s1_ren) n1r++;
      if (s0_valid && c0n < 9) begin s0_px[c0n] = s0_data; c0n++; end
      if (s1_valid && c1n < 9) begin s1_px[c1n] = s1_data; c1n++; end
      if (s0_done) d0 = 1;
      if (s1_done) d1 = 1;
      @(negedge clk);
    end
    chk("t3_done_both", {d0, d1}, 2'b11);
    chk("t3z_npix", c0n, 9);
    chk("t3c_npix", c1n, 9);
    chk("t3z_nren", n0r, 3);
    chk("t3c_nren", n1r, 9);
    for (int r = 0; r < 3; r++) begin
      a = (BASE + r * 8 + 7) & 255;
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("t3z_px_r%0d_c%0d", r, c), s0_px[r * 3 + c],
            (c == 0) ? a : 0);
        chk($sformatf("t3c_px_r%0d_c%0d", r, c), s1_px[r * 3 + c], a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
